// File: rtl/bus_uart_tx_if.sv
// CPU-side bus bundle for the memory-mapped UART transmitter.
// The CPU (master) drives address, strobes and write data; the UART answers with read data and a drive enable.
interface bus_uart_tx_if;
  logic [15:0] addr;
  logic [7:0]  in_data;
  logic [7:0]  out_data;
  logic        out_en;
  logic        ce;
  logic        r;
  logic        w;
  logic        oe;

  modport master (
    output addr, in_data, ce, r, w, oe,
    input  out_data, out_en
  );

  modport slave (
    input  addr, in_data, ce, r, w, oe,
    output out_data, out_en
  );
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus writes fill a TX FIFO, a frame FSM shifts bytes out LSB first.
// Registers: 0 TXDATA (W), 1 STATUS (R), 2 CTRL (RW, bit7 clears ovf), 3 reserved.
module bus_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_uart_tx_if.slave   bus,
  output logic           txd,
  output logic           irq
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic               ovf_q, ovf_d;
  logic               rd_pend_q, rd_pend_d;
  logic [7:0]         out_data_q, out_data_d;

  logic [7:0]         mem [FIFO_DEPTH];

  logic               sel, wr_stb, rd_stb, push, push_ok, ctrl_wr;
  logic [1:0]         reg_idx;
  logic [CNT_W-1:0]   count;
  logic [4:0]         count_ext;
  logic [3:0]         count_sat;
  logic               empty, full, busy, pop, baud_done, start_frame;
  logic [7:0]         rd_data;

  // Bus decode; a simultaneous write strobe suppresses the read.
  assign sel     = bus.ce & (bus.addr[15:2] == BASE_ADDR[15:2]);
  assign reg_idx = bus.addr[1:0];
  assign wr_stb  = sel & bus.w;
  assign rd_stb  = sel & bus.r & ~bus.w;
  assign push    = wr_stb & (reg_idx == 2'd0);
  assign push_ok = push & ~full;
  assign ctrl_wr = wr_stb & (reg_idx == 2'd2);

  // Extra pointer bit distinguishes full from empty.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign count_ext = 5'(count);
  assign count_sat = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];

  assign baud_done   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign start_frame = en_q & ~empty;

  // FIFO storage, no reset needed: validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= bus.in_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_frame) state_d = S_START;
      S_START: if (baud_done) state_d = S_DATA;
      S_DATA:  if (baud_done && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_done) state_d = start_frame ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    txd  = 1'b1;
    busy = (state_q != S_IDLE);
    pop  = 1'b0;
    case (state_q)
      S_IDLE:  pop = start_frame;
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      S_STOP:  pop = baud_done & start_frame;
      default: txd = 1'b1;
    endcase
  end

  // Serializer datapath and FIFO pointers
  always_comb begin
    baud_d   = '0;
    bit_d    = '0;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q + CNT_W'(push_ok);
    rd_ptr_d = rd_ptr_q + CNT_W'(pop);
    if (state_q != S_IDLE && !baud_done) begin
      baud_d = baud_q + 1'b1;
    end
    if (state_q == S_DATA) begin
      bit_d = baud_done ? bit_q + 3'd1 : bit_q;
    end
    if (pop) begin
      baud_d  = '0;
      shift_d = mem[rd_ptr_q[PTR_W-1:0]];
    end else if (state_q == S_DATA && baud_done) begin
      shift_d = {1'b0, shift_q[7:1]};
    end
  end

  // Control/status registers and read path; reads see pre-edge state.
  always_comb begin
    en_d  = en_q;
    ie_d  = ie_q;
    ovf_d = ovf_q;
    if (ctrl_wr) begin
      en_d = bus.in_data[0];
      ie_d = bus.in_data[1];
      if (bus.in_data[7]) ovf_d = 1'b0;
    end
    if (push && full) ovf_d = 1'b1;

    case (reg_idx)
      2'd1:    rd_data = {count_sat, ovf_q, busy, empty, full};
      2'd2:    rd_data = {6'd0, ie_q, en_q};
      default: rd_data = 8'd0;
    endcase
    rd_pend_d  = rd_stb;
    out_data_d = rd_stb ? rd_data : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      ovf_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      ovf_q      <= ovf_d;
      rd_pend_q  <= rd_pend_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_en   = rd_pend_q & bus.oe;
  assign irq          = empty & ie_q;

endmodule
